aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  AES-128 encryption sequencer. Owns the 128-bit state and round-key registers.
//  Drives the external round datapath (sub/shift/mix), key expansion and add_round_key
//  blocks one round per cycle, from the start handshake to the done pulse.
//  Sits between the SPI/load interface and the combinational AES cores.
// PARAMETERS
//  NR    10   number of rounds; only 10 is legal (rcon table covers rounds 1..10)
//  RW    4    round-counter width; must satisfy 2**RW > NR
// PORTS
//  clk         in   1    system clock, all flops on posedge
//  reset       in   1    asynchronous, active-low reset
//  start       in   1    level; sampled only in IDLE; captures pt/key
//  pt          in   128  plaintext, byte 0 in [127:120]
//  key         in   128  cipher key, same byte order
//  busy        out  1    high in every state except IDLE
//  done        out  1    one-cycle pulse in DONE
//  ct          out  128  ciphertext; valid from done, held until next capture
//  round       out  RW   current round index (0 in IDLE/INIT)
//  rnd_in      out  128  state register to sub/shift/mix datapath
//  rnd_mix_en  out  1    1 = apply MixColumns; 0 in FINAL
//  rnd_out     in   128  datapath result (combinational)
//  kx_key      out  128  round-key register to key expansion
//  kx_rcon     out  8    rcon for the key being generated
//  kx_next     in   128  next round key (combinational)
//  ark_a       out  128  add_round_key data operand
//  ark_w       out  128  add_round_key key operand (= round-key register)
//  ark_y       in   128  add_round_key result
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; st_q, key_q, ct, round = 0; busy=0, done=0.
//  FSM: IDLE -> INIT -> ROUND (x NR-1) -> FINAL -> DONE -> IDLE.
//  - IDLE:  start=1 -> st_q<=pt, key_q<=key, round<=0, go INIT; else hold.
//  - INIT:  ark_a=st_q; st_q<=ark_y; key_q<=kx_next with rcon[1]; round<=1; go ROUND.
//  - ROUND: ark_a=rnd_out, mix_en=1; st_q<=ark_y; key_q<=kx_next with rcon[round+1];
//           round<=round+1; if round==NR-1 go FINAL.
//  - FINAL: ark_a=rnd_out, mix_en=0; ct<=ark_y; key_q held; go DONE.
//  - DONE:  done=1 for this cycle only; round<=0; go IDLE.
//  ark_w=kx_key=key_q and rnd_in=st_q in all states. In IDLE/DONE, ark_a=st_q and
//  rnd_mix_en=1 (don't-care).
//  rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36; kx_rcon=00 outside INIT/ROUND.
//  Latency: start sampled at edge E0 -> done high during cycle after edge E0+NR+1 (12 cyc).
//  start while busy: ignored, no queueing. start held high through DONE: a new
//  capture occurs on the first IDLE cycle (back-to-back rate = 13 cycles/block).
//  ct changes only on the FINAL edge; pt/key may change freely after capture.
//  Reset mid-operation: immediate IDLE, ct cleared, no done pulse.
// CONFIGURATION
//  AES_ABORT_EN defined: adds port abort (in, 1). abort=1 in INIT/ROUND/FINAL -> next
//   state IDLE, round<=0, ct unchanged, no done. abort in IDLE/DONE: no effect. abort
//   wins over a same-cycle FINAL->DONE transition.
//  Undefined: no abort port; a started block always runs to DONE.
// TESTING
//  1 FIPS-197 C.1: key=000102..0f, pt=00112233..ff -> ct=69c4e0d86a7b0430d8cdb78070b4c55a,
//    done 12 cycles after start edge, busy high for 12 cycles.
//  2 FIPS-197 App.B: key=2b7e151628aed2a6abf7158809cf4f3c,
//    pt=3243f6a8885a308d313198a2e0370734 -> ct=3925841d02dc09fbdc118597196a0b32;
//    key_q after INIT = a0fafe1788542cb123a339392a6c7605.
//  3 start pulsed again at round 5 with a new pt -> ignored; ct still equals vector 1 result.
//  4 reset driven low at round 6, released -> IDLE, ct=0, no done; next start gives
//    the correct ct.
//  5 start held high for 30 cycles with the vector 1 inputs -> exactly two done pulses,
//    13 cycles apart, same ct.
//  6 (AES_ABORT_EN) abort at round 3 -> IDLE next cycle, no done, ct keeps the prior value.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// Bundle between the AES-128 round sequencer and its host/datapath peers.
// With AES_ABORT_EN defined the bundle also carries the abort request.
interface aes_round_ctrl_if #(
  parameter int RW = 4
);
  logic          start;
  logic [127:0]  pt;
  logic [127:0]  key;
  logic          busy;
  logic          done;
  logic [127:0]  ct;
  logic [RW-1:0] round;
  logic [127:0]  rnd_in;
  logic          rnd_mix_en;
  logic [127:0]  rnd_out;
  logic [127:0]  kx_key;
  logic [7:0]    kx_rcon;
  logic [127:0]  kx_next;
  logic [127:0]  ark_a;
  logic [127:0]  ark_w;
  logic [127:0]  ark_y;
`ifdef AES_ABORT_EN
  logic          abort;
`endif

  modport master (
`ifdef AES_ABORT_EN
    output abort,
`endif
    output start, pt, key, rnd_out, kx_next, ark_y,
    input  busy, done, ct, round, rnd_in, rnd_mix_en, kx_key, kx_rcon, ark_a, ark_w
  );

  modport slave (
`ifdef AES_ABORT_EN
    input  abort,
`endif
    input  start, pt, key, rnd_out, kx_next, ark_y,
    output busy, done, ct, round, rnd_in, rnd_mix_en, kx_key, kx_rcon, ark_a, ark_w
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 encryption sequencer: owns state/round-key registers, one round per cycle.
// Optional AES_ABORT_EN adds an abort request that returns INIT/ROUND/FINAL to IDLE.
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic             clk,
  input  logic             reset,
  aes_round_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [127:0]  st_r, st_s;
  logic [127:0]  key_r, key_s;
  logic [127:0]  ct_r, ct_s;
  logic [RW-1:0] round_r, round_s;
  logic          busy_r, done_r;
  logic [127:0]  ark_a_s;
  logic          mix_en_s;
  logic [7:0]    rcon_s;
  logic          abort_s;

  // Round constant for the key being generated (index 1..10).
  function automatic logic [7:0] rcon_of(input logic [RW-1:0] idx);
    logic [7:0] r;
    case (idx)
      RW'(1):  r = 8'h01;
      RW'(2):  r = 8'h02;
      RW'(3):  r = 8'h04;
      RW'(4):  r = 8'h08;
      RW'(5):  r = 8'h10;
      RW'(6):  r = 8'h20;
      RW'(7):  r = 8'h40;
      RW'(8):  r = 8'h80;
      RW'(9):  r = 8'h1b;
      RW'(10): r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

`ifdef AES_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  // Next-state, register updates and datapath operand selection.
  always_comb begin
    state_s  = state_r;
    st_s     = st_r;
    key_s    = key_r;
    ct_s     = ct_r;
    round_s  = round_r;
    ark_a_s  = st_r;
    mix_en_s = 1'b1;
    rcon_s   = 8'h00;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          st_s    = bus.pt;
          key_s   = bus.key;
          round_s = '0;
          state_s = S_INIT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_INIT: begin
        rcon_s  = rcon_of(RW'(1));
        st_s    = bus.ark_y;
        key_s   = bus.kx_next;
        round_s = RW'(1);
        state_s = S_ROUND;
      end
      S_ROUND: begin
        ark_a_s = bus.rnd_out;
        rcon_s  = rcon_of(round_r + RW'(1));
        st_s    = bus.ark_y;
        key_s   = bus.kx_next;
        round_s = round_r + RW'(1);
        if (round_r == RW'(NR - 1)) begin
          state_s = S_FINAL;
        end else begin
          state_s = S_ROUND;
        end
      end
      S_FINAL: begin
        ark_a_s  = bus.rnd_out;
        mix_en_s = 1'b0;
        ct_s     = bus.ark_y;
        state_s  = S_DONE;
      end
      S_DONE: begin
        round_s = '0;
        state_s = S_IDLE;
      end
      default: begin
        round_s = '0;
        state_s = S_IDLE;
      end
    endcase
    // Abort overrides any in-flight transition, including FINAL->DONE.
    if (abort_s && (state_r == S_INIT || state_r == S_ROUND || state_r == S_FINAL)) begin
      state_s = S_IDLE;
      round_s = '0;
      ct_s    = ct_r;
    end else begin
      state_s = state_s;
    end
  end

  // State, data registers and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      st_r    <= 128'd0;
      key_r   <= 128'd0;
      ct_r    <= 128'd0;
      round_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      st_r    <= st_s;
      key_r   <= key_s;
      ct_r    <= ct_s;
      round_r <= round_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= (state_s == S_DONE);
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.ct         = ct_r;
  assign bus.round      = round_r;
  assign bus.rnd_in     = st_r;
  assign bus.rnd_mix_en = mix_en_s;
  assign bus.kx_key     = key_r;
  assign bus.kx_rcon    = rcon_s;
  assign bus.ark_a      = ark_a_s;
  assign bus.ark_w      = key_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl; supplies a reference AES round/key-expansion model.
// Abort steps are compiled only when AES_ABORT_EN is defined.
module tb_aes_round_ctrl;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_mis;

  aes_round_ctrl_if #(.RW(4)) bus ();

  aes_round_ctrl #(.NR(10), .RW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK1 = 128'ha0fafe1788542cb123a339392a6c7605;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0]  sq = x;
    logic [7:0]  r  = 8'h01;
    logic [15:0] d;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    d = {r, r};
    return r ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic mix);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   m [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[r+4*c] = sbox(a[r+4*((c+r)%4)]);
    for (int c = 0; c < 4; c++) begin
      m[4*c]   = gmul(b[4*c], 8'h02) ^ gmul(b[4*c+1], 8'h03) ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+1] = b[4*c] ^ gmul(b[4*c+1], 8'h02) ^ gmul(b[4*c+2], 8'h03) ^ b[4*c+3];
      m[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(b[4*c+2], 8'h02) ^ gmul(b[4*c+3], 8'h03);
      m[4*c+3] = gmul(b[4*c], 8'h03) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(b[4*c+3], 8'h02);
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = mix ? m[i] : b[i];
    return o;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = k;
    t  = {w3[23:0], w3[31:24]};
    t  = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_comb begin
    bus.rnd_out = aes_round(bus.rnd_in, bus.rnd_mix_en);
    bus.kx_next = kexp(bus.kx_key, bus.kx_rcon);
    bus.ark_y   = bus.ark_a ^ bus.ark_w;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start one block from a negedge and watch 14 cycles after the capture edge.
  task automatic run_block(input logic [127:0] p, input logic [127:0] k,
                           output logic [127:0] kq1, output int busy_cnt,
                           output int done_at, output int done_cnt);
    busy_cnt = 0; done_at = 0; done_cnt = 0; kq1 = 128'd0;
    bus.pt = p; bus.key = k; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin done_cnt++; done_at = i; end
      if (i == 2) kq1 = bus.kx_key;
      tick();
    end
  endtask

  initial begin
    logic [127:0] kq1;
    int bc, da, dc, d1, d2, guard;
    bit pulsed;
    n_cmp = 0; n_mis = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.pt = 128'd0; bus.key = 128'd0;
`ifdef AES_ABORT_EN
    bus.abort = 1'b0;
`endif
    tick(); tick();
    chk("rst_busy",  128'(bus.busy), 128'd0);
    chk("rst_done",  128'(bus.done), 128'd0);
    chk("rst_ct",    bus.ct, 128'd0);
    chk("rst_round", 128'(bus.round), 128'd0);
    reset = 1'b1;
    tick();

    // FIPS-197 C.1
    run_block(P1, K1, kq1, bc, da, dc);
    chk("v1_ct",      bus.ct, C1);
    chk("v1_busy",    128'(bc), 128'd12);
    chk("v1_done_at", 128'(da), 128'd12);
    chk("v1_done_n",  128'(dc), 128'd1);

    // FIPS-197 Appendix B
    run_block(P2, K2, kq1, bc, da, dc);
    chk("v2_rk1", kq1, RK1);
    chk("v2_ct",  bus.ct, C2);

    // Start pulse mid-run must be ignored.
    bus.pt = P1; bus.key = K1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; pulsed = 1'b0; dc = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.done) dc++;
      if (bus.round == 4'd5 && !pulsed) begin
        bus.pt = P2; bus.start = 1'b1; pulsed = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    chk("ign_pulsed", 128'(pulsed), 128'd1);
    chk("ign_ct",     bus.ct, C1);
    chk("ign_done_n", 128'(dc), 128'd1);

    // Reset in round 6.
    bus.pt = P2; bus.key = K2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; guard = 0;
    while (bus.round != 4'd6 && guard < 20) begin tick(); guard++; end
    chk("rst6_reach", 128'(bus.round), 128'd6);
    reset = 1'b0;
    #1;
    chk("rst6_ct",    bus.ct, 128'd0);
    chk("rst6_busy",  128'(bus.busy), 128'd0);
    chk("rst6_round", 128'(bus.round), 128'd0);
    tick();
    reset = 1'b1;
    dc = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) dc++;
      tick();
    end
    chk("rst6_nodone", 128'(dc), 128'd0);
    run_block(P2, K2, kq1, bc, da, dc);
    chk("rst6_next_ct", bus.ct, C2);

    // Start held high for 30 cycles.
    bus.pt = P1; bus.key = K1; bus.start = 1'b1;
    dc = 0; d1 = 0; d2 = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.done) begin
        dc++;
        if (dc == 1) d1 = i;
        if (dc == 2) d2 = i;
        chk("held_ct", bus.ct, C1);
      end
    end
    bus.start = 1'b0;
    chk("held_done_n", 128'(dc), 128'd2);
    chk("held_gap",    128'(d2 - d1), 128'd13);
    for (int i = 0; i < 20; i++) tick();
    chk("held_idle", 128'(bus.busy), 128'd0);

`ifdef AES_ABORT_EN
    // Abort in round 3 keeps the previous ciphertext.
    bus.pt = P2; bus.key = K2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; guard = 0;
    while (bus.round != 4'd3 && guard < 20) begin tick(); guard++; end
    chk("ab_reach", 128'(bus.round), 128'd3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_busy",  128'(bus.busy), 128'd0);
    chk("ab_round", 128'(bus.round), 128'd0);
    chk("ab_ct",    bus.ct, C1);
    dc = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) dc++;
      tick();
    end
    chk("ab_nodone", 128'(dc), 128'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
